// File: rtl/hamming_secded_encoder_if.sv
// Valid/ready stream bundle for the SECDED encoder: data+mask in, codeword out.
interface hamming_secded_encoder_if #(
  parameter int R = 4
) ();
  localparam int K = 2**R - 1 - R;
  localparam int N = 2**R;

  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic [N-1:0] in_inj;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_codeword;

  modport master (
    output in_valid, in_data, in_inj, out_ready,
    input  in_ready, out_valid, out_codeword
  );

  modport slave (
    input  in_valid, in_data, in_inj, out_ready,
    output in_ready, out_valid, out_codeword
  );
endinterface

// File: rtl/hamming_secded_encoder.sv
// Two-stage extended-Hamming (SECDED) encoder with error injection and a
// completed-word counter; the whole pipeline advances on one global enable.
module hamming_secded_encoder #(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_secded_encoder_if.slave bus,
  output logic [CNT_W-1:0]       word_count
);
  localparam int K      = 2**R - 1 - R;
  localparam int N      = 2**R;
  localparam int STAGES = 2;

  // Codeword position of data bit j: j-th non-power-of-two index above 2.
  function automatic int data_pos(input int j);
    int c;
    data_pos = 0;
    c = 0;
    for (int p = 3; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        if (c == j) data_pos = p;
        c++;
      end
  endfunction

  logic [STAGES:0]       vld_pipe;
  logic                  en;
  logic [K-1:0]          s1_data;
  logic [N-1:0]          s1_inj;
  logic [N-1:0]          cw_reg;
  logic [N-1:1]          ham;
  logic [K-1:0][R-1:0]   pos_term;
  logic [R-1:0]          syn;
  logic [N-1:0]          cw;

  assign vld_pipe[0]      = bus.in_valid;
  assign en               = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready     = en;
  assign bus.out_valid    = vld_pipe[STAGES];
  assign bus.out_codeword = cw_reg;

  for (genvar j = 0; j < K; j++) begin : g_data
    localparam int              P  = data_pos(j);
    localparam logic [R-1:0]    PV = P[R-1:0];
    assign ham[P]      = s1_data[j];
    assign pos_term[j] = s1_data[j] ? PV : '0;
  end

  // Parity bits make the XOR of set-bit indices zero.
  always_comb begin
    syn = '0;
    for (int j = 0; j < K; j++) syn ^= pos_term[j];
  end

  for (genvar k = 0; k < R; k++) begin : g_par
    assign ham[2**k] = syn[k];
  end

  assign cw = {ham, ^ham};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      s1_data            <= '0;
      s1_inj             <= '0;
      cw_reg             <= '0;
      word_count         <= '0;
    end else begin
      if (en) begin
        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        s1_data            <= bus.in_data;
        s1_inj             <= bus.in_inj;
        cw_reg             <= cw ^ s1_inj;
      end
      if (vld_pipe[STAGES] && bus.out_ready) word_count <= word_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Directed-vector bench for hamming_secded_encoder: table vectors, backpressure,
// mid-stream reset, counter wrap and an R=3 / R=5 property sweep.
module tb_hamming_secded_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wc, wc3, wc5;
  logic [3:0]  wc_w;

  always #5 clk = ~clk;

  hamming_secded_encoder_if #(.R(4)) m ();
  hamming_secded_encoder_if #(.R(4)) w ();
  hamming_secded_encoder_if #(.R(3)) s3 ();
  hamming_secded_encoder_if #(.R(5)) s5 ();

  hamming_secded_encoder #(.R(4), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(m),  .word_count(wc));
  hamming_secded_encoder #(.R(4), .CNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(w),  .word_count(wc_w));
  hamming_secded_encoder #(.R(3), .CNT_W(16)) dut3  (.clk(clk), .rst(rst), .bus(s3), .word_count(wc3));
  hamming_secded_encoder #(.R(5), .CNT_W(16)) dut5  (.clk(clk), .rst(rst), .bus(s5), .word_count(wc5));

  typedef struct {
    logic [10:0] data;
    logic [15:0] inj;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[8];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] got[$];
  bit          bp_on = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_cw = '0;
  logic [31:0] q3[$], q5[$];
  int          bad3 = 0, n3 = 0, bad5 = 0, n5 = 0;
  bit          pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Decoder-side view: zero syndrome, even parity, data recoverable in place.
  function automatic bit code_ok(input logic [31:0] cw, input int r, input logic [31:0] data);
    logic [31:0] ext;
    int syn, par, j;
    ext = '0; syn = 0; par = 0; j = 0;
    for (int p = 0; p < (1 << r); p++) begin
      if (cw[p]) begin syn ^= p; par ^= 1; end
      if (p != 0 && (p & (p - 1)) != 0) begin ext[j] = cw[p]; j++; end
    end
    return (syn == 0) && (par == 0) && (ext == data);
  endfunction

  always @(negedge clk) begin
    if (!rst && m.out_valid && m.out_ready) got.push_back(m.out_codeword);
    if (bp_on) begin
      check("bp_in_ready", m.in_ready, !m.out_valid || m.out_ready);
      if (prev_stall) check("bp_stable", m.out_codeword, prev_cw);
    end
    prev_stall = m.out_valid && !m.out_ready;
    prev_cw    = m.out_codeword;
  end

  always @(negedge clk) begin
    if (!rst && s3.out_valid && s3.out_ready) begin
      n3++;
      if (q3.size() == 0) bad3++;
      else if (!code_ok(32'(s3.out_codeword), 3, q3.pop_front())) bad3++;
    end
    if (!rst && s5.out_valid && s5.out_ready) begin
      n5++;
      if (q5.size() == 0) bad5++;
      else if (!code_ok(32'(s5.out_codeword), 5, q5.pop_front())) bad5++;
    end
  end

  task automatic stream(input int lo, input int hi, input bit lat);
    for (int i = lo; i <= hi; i++) begin
      m.in_valid = 1'b1;
      m.in_data  = tbl[i].data;
      m.in_inj   = tbl[i].inj;
      @(posedge clk);
      @(negedge clk);
      if (lat && i == lo) check("lat_after_accept", m.out_valid, 1'b0);
      if (lat && i == lo + 1) begin
        check("lat_valid", m.out_valid, 1'b1);
        check("lat_word", m.out_codeword, tbl[lo].exp);
      end
    end
    m.in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_got(input int lo, input int hi);
    check("got_size", got.size(), hi - lo + 1);
    for (int i = lo; i <= hi; i++)
      check($sformatf("word%0d", i), (i - lo < got.size()) ? got[i - lo] : 16'hxxxx, tbl[i].exp);
  endtask

  initial begin
    bit acc;
    int idx, cyc;
    tbl[0] = '{11'h000, 16'h0000, 16'h0000};
    tbl[1] = '{11'h001, 16'h0000, 16'h000F};
    tbl[2] = '{11'h42D, 16'h0000, 16'h84DE};
    tbl[3] = '{11'h7FF, 16'h0000, 16'hFFFF};
    tbl[4] = '{11'h42D, 16'h0008, 16'h84D6};
    tbl[5] = '{11'h42D, 16'h0009, 16'h84D7};
    tbl[6] = '{11'h002, 16'h0000, 16'h0033};
    tbl[7] = '{11'h400, 16'h0000, 16'h8117};

    m.in_valid = 1'b1; m.in_data = 11'h7FF; m.in_inj = '0; m.out_ready = 1'b1;
    w.in_valid = 1'b0; w.in_data = '0; w.in_inj = '0; w.out_ready = 1'b1;
    s3.in_valid = 1'b0; s3.in_data = '0; s3.in_inj = '0; s3.out_ready = 1'b1;
    s5.in_valid = 1'b0; s5.in_data = '0; s5.in_inj = '0; s5.out_ready = 1'b1;

    // Reset held two cycles with a word offered
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", m.out_valid, 1'b0);
      check("rst_codeword", m.out_codeword, 16'h0000);
      check("rst_count", wc, 16'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", m.in_ready, 1'b1);

    got.delete();
    stream(0, 3, 1'b1);
    compare_got(0, 3);
    check("count_after_4", wc, 16'd4);

    got.delete();
    stream(4, 7, 1'b0);
    compare_got(4, 7);
    check("count_after_8", wc, 16'd8);

    // Backpressure with a toggling sink
    got.delete();
    bp_on = 1'b1;
    idx = 0; cyc = 0;
    @(posedge clk); #1;
    while (got.size() < 6 && cyc < 100) begin
      m.out_ready = pat[cyc % 8];
      m.in_valid  = (idx < 6);
      m.in_data   = tbl[idx].data;
      m.in_inj    = tbl[idx].inj;
      @(negedge clk);
      acc = m.in_valid && m.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bp_on = 1'b0;
    m.in_valid = 1'b0;
    m.out_ready = 1'b1;
    compare_got(0, 5);
    check("bp_count", wc, 16'd14);

    // Mid-stream reset with two stalled words in flight
    got.delete();
    m.out_ready = 1'b0;
    m.in_valid = 1'b1; m.in_data = tbl[2].data; m.in_inj = '0;
    @(posedge clk); #1;
    m.in_data = tbl[3].data;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    @(negedge clk);
    check("mid_inflight", m.out_valid, 1'b1);
    #1;
    rst = 1'b1;
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_no_output", got.size(), 0);
    check("mid_count", wc, 16'd0);
    check("mid_out_valid", m.out_valid, 1'b0);

    // 17 transfers into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      w.in_valid = 1'b1; w.in_data = 11'(i);
      @(posedge clk); #1;
    end
    w.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("wrap_count", wc_w, 4'd1);

    // R=3 exhaustive
    for (int v = 0; v < 16; v++) begin
      s3.in_valid = 1'b1; s3.in_data = 4'(v); q3.push_back(32'(v));
      @(posedge clk); #1;
    end
    s3.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("r3_bad", bad3, 0);
    check("r3_seen", n3, 16);

    // R=5 random
    for (int v = 0; v < 10000; v++) begin
      logic [25:0] d;
      d = 26'($urandom);
      s5.in_valid = 1'b1; s5.in_data = d; q5.push_back(32'(d));
      @(posedge clk); #1;
    end
    s5.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("r5_bad", bad5, 0);
    check("r5_seen", n5, 10000);
    check("r5_count", wc5, 16'd10000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
